// File: rtl/port_spi_master.sv
// ---------------------------------------------------------------------------
// port_spi_master
//   SPI master (mode 0, MSB first, 8-bit frames) living on the CPU port bus.
//   Firmware writes DATA to launch a frame, polls CTRL for done/busy, reads
//   DATA for the received byte, and drives chip select by hand via CTRL[0].
//   in_port is a combinational read mux so several responders can be ORed.
//
// Ports
//   clk, resetn       system clock (rising edge), async active-low reset
//   port_id           CPU port address (DATA=BASE_PORT, CTRL=+1, DIV=+2)
//   write_strobe      write request, out_port carries the data
//   out_port          write data
//   read_strobe       read request
//   in_port           read data, 8'h00 for unmapped port_id
//   spi_sclk          SPI clock, idles low
//   spi_mosi          SPI data out, holds last bit after a frame
//   spi_miso          SPI data in, sampled when spi_sclk rises
//   spi_cs_n          chip select, ~CTRL[0], registered
//   dbg_state_o       FSM state (0=IDLE, 1=LOW, 2=HIGH) for observation
//
// Register map
//   DATA wr: start frame when idle, else flag overrun. DATA rd: RX, clears done.
//   CTRL wr: cs_en=out_port[0]. CTRL rd: {4'b0,done,ovr,cs_en,busy}, clears ovr.
//   DIV  rd/wr: SCLK half-period is DIV+1 clk cycles, latched per frame.
//
// Handshake: a strobe side effect fires once, on the first high cycle of the
// strobe (strobe & ~strobe_q) for a matching port_id; in_port is valid in
// that same cycle because the CPU registers it at that edge.
// ---------------------------------------------------------------------------
module port_spi_master #(
    parameter logic [7:0] BASE_PORT = 8'h10,
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n,
    output logic [1:0] dbg_state_o
);

    localparam logic [7:0] PORT_DATA = BASE_PORT;
    localparam logic [7:0] PORT_CTRL = BASE_PORT + 8'd1;
    localparam logic [7:0] PORT_DIV  = BASE_PORT + 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t     state_q, state_d;

    logic       wr_q, rd_q;
    logic [7:0] sh_q, sh_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] hc_q, hc_d;
    logic       rxb_q, rxb_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] div_q, div_d;
    logic [7:0] div_lat_q, div_lat_d;
    logic       done_q, done_d;
    logic       ovr_q, ovr_d;
    logic       cs_en_q, cs_en_d;
    logic       cs_n_q;

    logic       sel_data, sel_ctrl, sel_div;
    logic       wr_edge, rd_edge;
    logic       busy, start, hc_zero, last_bit;
    logic       done_set, ovr_set;

    assign sel_data = (port_id == PORT_DATA);
    assign sel_ctrl = (port_id == PORT_CTRL);
    assign sel_div  = (port_id == PORT_DIV);

    assign wr_edge  = write_strobe & ~wr_q;
    assign rd_edge  = read_strobe & ~rd_q;

    assign busy     = (state_q != ST_IDLE);
    assign start    = wr_edge & sel_data & ~busy;
    assign ovr_set  = wr_edge & sel_data & busy;
    assign hc_zero  = (hc_q == 8'd0);
    assign last_bit = (bit_q == 3'd0);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)   state_d = ST_LOW;
            ST_LOW:  if (hc_zero) state_d = ST_HIGH;
            ST_HIGH: if (hc_zero) state_d = last_bit ? ST_IDLE : ST_LOW;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        sh_d      = sh_q;
        bit_d     = bit_q;
        hc_d      = hc_q;
        rxb_d     = rxb_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        rx_d      = rx_q;
        div_lat_d = div_lat_q;
        done_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_d      = out_port;
                    bit_d     = 3'd7;
                    mosi_d    = out_port[7];
                    hc_d      = div_q;
                    div_lat_d = div_q;
                end
            end
            ST_LOW: begin
                if (hc_zero) begin
                    sclk_d = 1'b1;
                    rxb_d  = spi_miso;
                    hc_d   = div_lat_q;
                end else begin
                    hc_d = hc_q - 8'd1;
                end
            end
            ST_HIGH: begin
                if (hc_zero) begin
                    sclk_d = 1'b0;
                    sh_d   = {sh_q[6:0], rxb_q};
                    if (last_bit) begin
                        rx_d     = {sh_q[6:0], rxb_q};
                        done_set = 1'b1;
                    end else begin
                        // sh_q[6] is the next bit once the shift lands
                        bit_d  = bit_q - 3'd1;
                        mosi_d = sh_q[6];
                        hc_d   = div_lat_q;
                    end
                end else begin
                    hc_d = hc_q - 8'd1;
                end
            end
            default: ;
        endcase

        // Set wins over the read-side clear when both land on one edge
        done_d  = done_set | (done_q & ~(rd_edge & sel_data));
        ovr_d   = ovr_set | (ovr_q & ~(rd_edge & sel_ctrl));
        cs_en_d = (wr_edge & sel_ctrl) ? out_port[0] : cs_en_q;
        div_d   = (wr_edge & sel_div) ? out_port : div_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            sh_q      <= 8'h00;
            bit_q     <= 3'd0;
            hc_q      <= 8'h00;
            rxb_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            rx_q      <= 8'h00;
            div_q     <= DIV_RESET;
            div_lat_q <= DIV_RESET;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            cs_en_q   <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            wr_q      <= write_strobe;
            rd_q      <= read_strobe;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            hc_q      <= hc_d;
            rxb_q     <= rxb_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            rx_q      <= rx_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            cs_en_q   <= cs_en_d;
            cs_n_q    <= ~cs_en_d;
        end
    end

    // Read mux, zero when not addressed so responders can be ORed
    always_comb begin
        in_port = 8'h00;
        if (sel_data) in_port = rx_q;
        if (sel_ctrl) in_port = {4'b0000, done_q, ovr_q, cs_en_q, busy};
        if (sel_div)  in_port = div_q;
    end

    assign spi_sclk    = sclk_q;
    assign spi_mosi    = mosi_q;
    assign spi_cs_n    = cs_n_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_port_spi_master.sv
module tb_port_spi_master;

    localparam logic [7:0] P_DATA = 8'h10;
    localparam logic [7:0] P_CTRL = 8'h11;
    localparam logic [7:0] P_DIV  = 8'h12;
    localparam logic [7:0] P_NONE = 8'h20;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic       write_strobe = 1'b0;
    logic [7:0] out_port = 8'h00;
    logic       read_strobe = 1'b0;
    logic [7:0] in_port;
    logic       spi_sclk, spi_mosi, spi_miso, spi_cs_n;
    logic [1:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    port_spi_master #(.BASE_PORT(8'h10), .DIV_RESET(8'd3)) dut (
        .clk(clk), .resetn(resetn), .port_id(port_id),
        .write_strobe(write_strobe), .out_port(out_port),
        .read_strobe(read_strobe), .in_port(in_port),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .dbg_state_o(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // SPI slave: presents the next bit while SCLK is low, noise while high
    int         fall_cnt = 0;
    int         fall_base = 0;
    int         k_idx;
    logic [7:0] slave_byte = 8'h00;
    logic       noise = 1'b0;
    logic [7:0] mosi_cap = 8'h00;

    always @(negedge spi_sclk) fall_cnt <= fall_cnt + 1;
    always @(negedge clk) noise <= 1'($urandom_range(0, 1));
    always @(posedge spi_sclk) mosi_cap <= {mosi_cap[6:0], spi_mosi};

    always_comb begin
        k_idx = fall_cnt - fall_base;
        if (spi_sclk)
            spi_miso = noise;
        else if (k_idx >= 0 && k_idx < 8)
            spi_miso = slave_byte[3'(7 - k_idx)];
        else
            spi_miso = 1'b0;
    end

    // Timing monitor: frame length, SCLK phase lengths, idle gaps, frame count
    int run = 0, last_len = 0, frames = 0;
    int hi_run = 0, hi_len = 0, lo_run = 0, lo_len = 0;
    int idle_run = 0, gap_len = 0;

    always @(posedge clk) begin
        if (dbg_state != 2'd0) begin
            run <= run + 1;
            if (idle_run != 0) begin
                gap_len  <= idle_run;
                idle_run <= 0;
            end
        end else begin
            idle_run <= idle_run + 1;
            if (run != 0) begin
                last_len <= run;
                run      <= 0;
                frames   <= frames + 1;
            end
        end
        if (spi_sclk) hi_run <= hi_run + 1;
        else if (hi_run != 0) begin
            hi_len <= hi_run;
            hi_run <= 0;
        end
        if (!spi_sclk && dbg_state != 2'd0) lo_run <= lo_run + 1;
        else if (spi_sclk && lo_run != 0) begin
            lo_len <= lo_run;
            lo_run <= 0;
        end
    end

    // Driver tasks
    task automatic bus_write(input logic [7:0] port, input logic [7:0] data,
                             input int hold, input bit align);
        if (align) @(negedge clk);
        port_id      = port;
        out_port     = data;
        write_strobe = 1'b1;
        repeat (hold) @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] port, output logic [7:0] data);
        @(negedge clk);
        port_id     = port;
        read_strobe = 1'b1;
        #1 data = in_port;
        repeat (2) @(negedge clk);
        read_strobe = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] tx, input logic [7:0] slv,
                               input int hold, input bit align);
        slave_byte = slv;
        fall_base  = fall_cnt;
        bus_write(P_DATA, tx, hold, align);
    endtask

    // Returns at the first negedge after the FSM is back in IDLE
    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (dbg_state != 2'd0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (dbg_state != 2'd0) begin
            miscompares++;
            $display("FAIL wait_idle: frame still busy after %0d cycles", bound);
        end
    endtask

    // Tests
    task automatic test_reset();
        logic [7:0] d;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        bus_write(P_DIV, 8'd7, 2, 1);
        bus_write(P_CTRL, 8'h01, 2, 1);
        start_frame(8'hFF, 8'h00, 2, 1);
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        vectors++;
        if (spi_sclk !== 1'b0) begin miscompares++; $display("FAIL rst_sclk: got %b expected 0", spi_sclk); end
        vectors++;
        if (spi_cs_n !== 1'b1) begin miscompares++; $display("FAIL rst_cs_n: got %b expected 1", spi_cs_n); end
        vectors++;
        if (spi_mosi !== 1'b0) begin miscompares++; $display("FAIL rst_mosi: got %b expected 0", spi_mosi); end
        port_id = P_CTRL;
        #1;
        vectors++;
        if (in_port !== 8'h00) begin miscompares++; $display("FAIL rst_ctrl: got %h expected 00", in_port); end
        port_id = P_DIV;
        #1;
        vectors++;
        if (in_port !== 8'h03) begin miscompares++; $display("FAIL rst_div: got %h expected 03", in_port); end
        port_id = P_DATA;
        #1;
        vectors++;
        if (in_port !== 8'h00) begin miscompares++; $display("FAIL rst_rx: got %h expected 00", in_port); end
        @(negedge clk);
        resetn = 1'b1;
        bus_read(P_CTRL, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL rst_ctrl_rd: got %h expected 00", d); end
    endtask

    task automatic test_div0_frame();
        logic [7:0] d, e;
        bus_write(P_DIV, 8'd0, 2, 1);
        bus_write(P_CTRL, 8'h01, 2, 1);
        vectors++;
        if (spi_cs_n !== 1'b0) begin miscompares++; $display("FAIL cs_assert: got %b expected 0", spi_cs_n); end
        exp_q.push_back(8'h3C);
        start_frame(8'hA5, 8'h3C, 2, 1);
        wait_idle(200);
        @(negedge clk);
        vectors++;
        if (last_len !== 16) begin miscompares++; $display("FAIL div0_len: got %0d expected 16", last_len); end
        vectors++;
        if (mosi_cap !== 8'hA5) begin miscompares++; $display("FAIL div0_mosi: got %h expected a5", mosi_cap); end
        vectors++;
        if (spi_sclk !== 1'b0) begin miscompares++; $display("FAIL div0_sclk_end: got %b expected 0", spi_sclk); end
        vectors++;
        if (spi_mosi !== 1'b1) begin miscompares++; $display("FAIL div0_mosi_hold: got %b expected 1", spi_mosi); end
        bus_read(P_CTRL, d);
        vectors++;
        if (d !== 8'h0A) begin miscompares++; $display("FAIL div0_done: got %h expected 0a", d); end
        bus_read(P_DATA, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL div0_rx: got %h expected %h", d, e); end
        bus_read(P_CTRL, d);
        vectors++;
        if (d !== 8'h02) begin miscompares++; $display("FAIL div0_done_clr: got %h expected 02", d); end
    endtask

    task automatic test_div4_timing();
        logic [7:0] d, e;
        bus_write(P_DIV, 8'd4, 2, 1);
        exp_q.push_back(8'h96);
        start_frame(8'h5A, 8'h96, 2, 1);
        wait_idle(500);
        @(negedge clk);
        vectors++;
        if (last_len !== 80) begin miscompares++; $display("FAIL div4_len: got %0d expected 80", last_len); end
        vectors++;
        if (hi_len !== 5) begin miscompares++; $display("FAIL div4_high: got %0d expected 5", hi_len); end
        vectors++;
        if (lo_len !== 5) begin miscompares++; $display("FAIL div4_low: got %0d expected 5", lo_len); end
        vectors++;
        if (mosi_cap !== 8'h5A) begin miscompares++; $display("FAIL div4_mosi: got %h expected 5a", mosi_cap); end
        bus_read(P_DATA, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL div4_rx: got %h expected %h", d, e); end
    endtask

    task automatic test_overrun();
        logic [7:0] d, e;
        bus_write(P_DIV, 8'd2, 2, 1);
        exp_q.push_back(8'hC3);
        start_frame(8'h3E, 8'hC3, 2, 1);
        bus_write(P_DATA, 8'h11, 2, 1);
        bus_read(P_CTRL, d);
        vectors++;
        if (d !== 8'h07) begin miscompares++; $display("FAIL ovr_set: got %h expected 07", d); end
        wait_idle(500);
        @(negedge clk);
        vectors++;
        if (last_len !== 48) begin miscompares++; $display("FAIL ovr_len: got %0d expected 48", last_len); end
        vectors++;
        if (mosi_cap !== 8'h3E) begin miscompares++; $display("FAIL ovr_mosi: got %h expected 3e", mosi_cap); end
        bus_read(P_CTRL, d);
        vectors++;
        if (d !== 8'h0A) begin miscompares++; $display("FAIL ovr_clr: got %h expected 0a", d); end
        bus_read(P_DATA, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL ovr_rx: got %h expected %h", d, e); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, e;
        int f0;
        bus_write(P_DIV, 8'd1, 2, 1);
        f0 = frames;
        exp_q.push_back(8'h7E);
        start_frame(8'h81, 8'h7E, 4, 1);
        bus_write(P_DIV, 8'd3, 2, 1);
        wait_idle(500);
        @(negedge clk);
        vectors++;
        if (frames - f0 !== 1) begin miscompares++; $display("FAIL one_frame: got %0d expected 1", frames - f0); end
        vectors++;
        if (last_len !== 32) begin miscompares++; $display("FAIL old_div_len: got %0d expected 32", last_len); end
        bus_read(P_CTRL, d);
        vectors++;
        if (d !== 8'h0A) begin miscompares++; $display("FAIL hold_no_ovr: got %h expected 0a", d); end
        bus_read(P_DATA, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL b2b_rx1: got %h expected %h", d, e); end
        // Frame A, then frame B launched in A's first idle cycle
        start_frame(8'h24, 8'h00, 2, 1);
        wait_idle(500);
        exp_q.push_back(8'h18);
        start_frame(8'h42, 8'h18, 2, 0);
        vectors++;
        if (gap_len !== 1) begin miscompares++; $display("FAIL b2b_gap: got %0d expected 1", gap_len); end
        wait_idle(500);
        @(negedge clk);
        vectors++;
        if (last_len !== 64) begin miscompares++; $display("FAIL new_div_len: got %0d expected 64", last_len); end
        vectors++;
        if (mosi_cap !== 8'h42) begin miscompares++; $display("FAIL b2b_mosi: got %h expected 42", mosi_cap); end
        bus_read(P_DATA, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL b2b_rx2: got %h expected %h", d, e); end
        bus_read(P_DIV, d);
        vectors++;
        if (d !== 8'd3) begin miscompares++; $display("FAIL div_rd: got %h expected 03", d); end
    endtask

    task automatic test_unmapped_and_collide();
        logic [7:0] d, e;
        int f0;
        f0 = frames;
        bus_read(P_NONE, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL unmapped_rd: got %h expected 00", d); end
        bus_write(P_NONE, 8'hFF, 2, 1);
        repeat (2) @(negedge clk);
        vectors++;
        if (frames !== f0 || dbg_state !== 2'd0) begin
            miscompares++; $display("FAIL unmapped_wr_frame: got frames %0d expected %0d", frames, f0);
        end
        bus_read(P_DIV, d);
        vectors++;
        if (d !== 8'd3) begin miscompares++; $display("FAIL unmapped_div: got %h expected 03", d); end
        bus_read(P_CTRL, d);
        vectors++;
        if (d !== 8'h02) begin miscompares++; $display("FAIL unmapped_ctrl: got %h expected 02", d); end
        // DIV=0 frame ends exactly on the edge where a DATA read strobe starts
        bus_write(P_DIV, 8'd0, 2, 1);
        exp_q.push_back(8'h5C);
        slave_byte = 8'h5C;
        fall_base  = fall_cnt;
        @(negedge clk);
        port_id = P_DATA; out_port = 8'hC5; write_strobe = 1'b1;
        repeat (2) @(negedge clk);
        write_strobe = 1'b0;
        repeat (14) @(negedge clk);
        read_strobe = 1'b1;
        repeat (2) @(negedge clk);
        read_strobe = 1'b0;
        @(negedge clk);
        vectors++;
        if (last_len !== 16) begin miscompares++; $display("FAIL collide_len: got %0d expected 16", last_len); end
        bus_read(P_CTRL, d);
        vectors++;
        if (d !== 8'h0A) begin miscompares++; $display("FAIL collide_done: got %h expected 0a", d); end
        bus_read(P_DATA, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL collide_rx: got %h expected %h", d, e); end
        bus_read(P_CTRL, d);
        vectors++;
        if (d !== 8'h02) begin miscompares++; $display("FAIL collide_done_clr: got %h expected 02", d); end
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL sb_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_div0_frame();
        test_div4_timing();
        test_overrun();
        test_back_to_back();
        test_unmapped_and_collide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
